// File: rtl/memory_arbiter.sv
// Arbitrates instruction and data requests onto a single RAM port, data first,
// with a per-transaction timeout and a sticky fault state cleared only by reset.
module memory_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] iaddr,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        ihit,
    output logic        dhit,
    output logic [31:0] iload,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        err
);

    localparam int unsigned CNT_W = 5;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DATA  = 2'd1,
        INST  = 2'd2,
        FAULT = 2'd3
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic             take_d;
    logic             take_i;
    logic             load_d;
    logic             load_i;
    logic             cnt_inc;
    logic             timed_out;

    // Counter saturates, so a TIMEOUT beyond its range simply never expires.
    assign timed_out = (32'(cnt) >= (TIMEOUT - 32'd1));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and hit decode; hits are issued in the ACCESS cycle itself.
    always_comb begin
        state_next = state;
        ihit       = 1'b0;
        dhit       = 1'b0;
        take_d     = 1'b0;
        take_i     = 1'b0;
        load_d     = 1'b0;
        load_i     = 1'b0;
        cnt_inc    = 1'b0;
        case (state)
            IDLE: begin
                if (dREN || dWEN) begin
                    take_d     = 1'b1;
                    state_next = DATA;
                end else if (iREN) begin
                    take_i     = 1'b1;
                    state_next = INST;
                end
            end
            DATA, INST: begin
                if (ramstate == RAM_ACCESS) begin
                    state_next = IDLE;
                    if (state == DATA) begin
                        dhit   = 1'b1;
                        load_d = ramREN;
                    end else begin
                        ihit   = 1'b1;
                        load_i = 1'b1;
                    end
                end else if (ramstate == RAM_ERROR) begin
                    state_next = FAULT;
                end else if (timed_out) begin
                    state_next = FAULT;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            FAULT: begin
                state_next = FAULT;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Request latch doubles as the RAM-side drive, so live inputs never reach the RAM mid-transaction.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ramaddr  <= '0;
            ramstore <= '0;
            ramREN   <= 1'b0;
            ramWEN   <= 1'b0;
        end else if (take_d) begin
            ramaddr  <= daddr;
            ramstore <= dstore;
            ramREN   <= ~dWEN;
            ramWEN   <= dWEN;
        end else if (take_i) begin
            ramaddr  <= iaddr;
            ramREN   <= 1'b1;
            ramWEN   <= 1'b0;
        end else if ((state_next == IDLE) || (state_next == FAULT)) begin
            ramREN   <= 1'b0;
            ramWEN   <= 1'b0;
        end
    end

    // Per-transaction cycle counter, cleared on accept.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt <= '0;
        end else if (take_d || take_i) begin
            cnt <= '0;
        end else if (cnt_inc && (cnt != CNT_MAX)) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    // Read data capture and sticky fault flag.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            iload <= '0;
            dload <= '0;
            err   <= 1'b0;
        end else begin
            if (load_d) begin
                dload <= ramload;
            end
            if (load_i) begin
                iload <= ramload;
            end
            err <= (state_next == FAULT);
        end
    end

endmodule
